// File: rtl/cavlc_coef_buf.sv
// Ping-pong coefficient buffer between the CAVLC decoder and the inverse transform.
// Coefficients arrive in zig-zag scan order and are streamed out in raster order, one 4x4 block per bank.
module cavlc_coef_buf #(
    parameter int unsigned LEVEL_W = 13
) (
    input  logic                      Clk,
    input  logic                      nReset,
    input  logic signed [LEVEL_W-1:0] LevelIn,
    input  logic                      WrReq,
    input  logic                      BlockDone,
    output logic                      Full,
    output logic signed [LEVEL_W-1:0] CoefOut,
    output logic [3:0]                CoefIdx,
    output logic                      CoefValid,
    input  logic                      CoefReady,
    output logic                      CoefLast,
    output logic                      Overflow
);

    typedef enum logic {StIdle, StSend} state_e;

    state_e stateQ, stateD;

    logic signed [LEVEL_W-1:0] mem [2][16];
    logic [1:0][15:0]          maskQ, maskD;
    logic [1:0]                bankFullQ, bankFullD;
    logic                      wrPtrQ, rdPtrQ, rdPtrD;
    logic [4:0]                wrCntQ;
    logic                      overflowQ;

    logic                      coefValidQ, coefLastQ;
    logic signed [LEVEL_W-1:0] coefOutQ;
    logic [3:0]                coefIdxQ;

    logic                      wrEn, closeBlk, ovfSet;
    logic [3:0]                wrAddr;
    logic                      xfer, freeEn, loadEn, loadBank;
    logic [3:0]                loadIdx;
    logic signed [LEVEL_W-1:0] loadData;

    function automatic logic [3:0] zzMap(input logic [3:0] scanPos);
        logic [3:0] r;
        case (scanPos)
            4'd0:  r = 4'd0;
            4'd1:  r = 4'd1;
            4'd2:  r = 4'd4;
            4'd3:  r = 4'd8;
            4'd4:  r = 4'd5;
            4'd5:  r = 4'd2;
            4'd6:  r = 4'd3;
            4'd7:  r = 4'd6;
            4'd8:  r = 4'd9;
            4'd9:  r = 4'd12;
            4'd10: r = 4'd13;
            4'd11: r = 4'd10;
            4'd12: r = 4'd7;
            4'd13: r = 4'd11;
            4'd14: r = 4'd14;
            default: r = 4'd15;
        endcase
        return r;
    endfunction

    assign Full = bankFullQ[0] & bankFullQ[1];

    // Write side: while Full, every decoder request is dropped and flagged.
    always_comb begin
        wrEn     = WrReq && !Full && (wrCntQ < 5'd16) && !bankFullQ[wrPtrQ];
        closeBlk = BlockDone && !Full;
        ovfSet   = (Full && (WrReq || BlockDone)) || (WrReq && !Full && (wrCntQ == 5'd16));
        wrAddr   = zzMap(wrCntQ[3:0]);
    end

    // Read FSM: loadEn fetches the next output word, freeEn releases the read bank.
    always_comb begin
        stateD   = stateQ;
        rdPtrD   = rdPtrQ;
        freeEn   = 1'b0;
        loadEn   = 1'b0;
        loadBank = rdPtrQ;
        loadIdx  = 4'd0;
        xfer     = coefValidQ && CoefReady;
        case (stateQ)
            StIdle: begin
                if (bankFullQ[rdPtrQ]) begin
                    stateD = StSend;
                    loadEn = 1'b1;
                end
            end
            StSend: begin
                if (xfer) begin
                    if (coefIdxQ != 4'd15) begin
                        loadEn  = 1'b1;
                        loadIdx = coefIdxQ + 4'd1;
                    end else begin
                        freeEn = 1'b1;
                        rdPtrD = ~rdPtrQ;
                        if (bankFullQ[~rdPtrQ]) begin
                            loadEn   = 1'b1;
                            loadBank = ~rdPtrQ;
                        end else begin
                            stateD = StIdle;
                        end
                    end
                end
            end
            default: stateD = StIdle;
        endcase
        loadData = maskQ[loadBank][loadIdx] ? mem[loadBank][loadIdx] : '0;
    end

    // Free and close always target different banks, so both may land in one cycle.
    always_comb begin
        bankFullD = bankFullQ;
        maskD     = maskQ;
        if (wrEn) maskD[wrPtrQ][wrAddr] = 1'b1;
        if (closeBlk) bankFullD[wrPtrQ] = 1'b1;
        if (freeEn) begin
            bankFullD[rdPtrQ] = 1'b0;
            maskD[rdPtrQ]     = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (wrEn) mem[wrPtrQ][wrAddr] <= LevelIn;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            stateQ     <= StIdle;
            maskQ      <= '0;
            bankFullQ  <= '0;
            wrPtrQ     <= 1'b0;
            rdPtrQ     <= 1'b0;
            wrCntQ     <= 5'd0;
            overflowQ  <= 1'b0;
            coefValidQ <= 1'b0;
            coefOutQ   <= '0;
            coefIdxQ   <= 4'd0;
            coefLastQ  <= 1'b0;
        end else begin
            stateQ    <= stateD;
            maskQ     <= maskD;
            bankFullQ <= bankFullD;
            rdPtrQ    <= rdPtrD;
            if (ovfSet) overflowQ <= 1'b1;
            if (closeBlk) begin
                wrPtrQ <= ~wrPtrQ;
                wrCntQ <= 5'd0;
            end else if (wrEn) begin
                wrCntQ <= wrCntQ + 5'd1;
            end
            if (loadEn) begin
                coefValidQ <= 1'b1;
                coefOutQ   <= loadData;
                coefIdxQ   <= loadIdx;
                coefLastQ  <= (loadIdx == 4'd15);
            end else if (freeEn) begin
                coefValidQ <= 1'b0;
                coefOutQ   <= '0;
                coefIdxQ   <= 4'd0;
                coefLastQ  <= 1'b0;
            end
        end
    end

    assign CoefValid = coefValidQ;
    assign CoefOut   = coefOutQ;
    assign CoefIdx   = coefIdxQ;
    assign CoefLast  = coefLastQ;
    assign Overflow  = overflowQ;

endmodule

// File: doc/cavlc_coef_buf.md
CAVLC_COEF_BUF -- requirements
Module: cavlc_coef_buf

Interface
REQ-001 SHALL have parameter LEVEL_W, default 13, meaning the coefficient width (matches the decoder LevelOut).
REQ-002 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port nReset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port LevelIn, input, LEVEL_W bits: signed coefficient from the CAVLC decoder LevelOut, in zig-zag scan order.
REQ-005 SHALL have port WrReq, input, 1 bit: LevelIn valid this cycle (decoder write strobe).
REQ-006 SHALL have port BlockDone, input, 1 bit: single-cycle pulse closing the current 4x4 block.
REQ-007 SHALL have port Full, output, 1 bit: both banks occupied; the upstream decoder must stall.
REQ-008 SHALL have port CoefOut, output, LEVEL_W bits: coefficient in raster order.
REQ-009 SHALL have port CoefIdx, output, 4 bits: raster position of CoefOut, 0..15.
REQ-010 SHALL have port CoefValid, output, 1 bit: CoefOut/CoefIdx/CoefLast are valid.
REQ-011 SHALL have port CoefReady, input, 1 bit: downstream accepts; a transfer occurs when CoefValid and CoefReady are both high.
REQ-012 SHALL have port CoefLast, output, 1 bit: high with CoefIdx==15.
REQ-013 SHALL have port Overflow, output, 1 bit: sticky error flag, cleared only by reset.

Function
REQ-014 SHALL hold two 16 x LEVEL_W banks (ping-pong) plus a 16-bit written-mask per bank; each bank is either FREE or FULL.
REQ-015 SHALL keep a 5-bit write counter WrCnt for the bank currently being written; WrCnt resets to 0 on each bank switch.
REQ-016 SHALL, on WrReq with WrCnt<16 and the write bank FREE, store LevelIn at raster address ZZ[WrCnt], set that mask bit, and increment WrCnt.
REQ-017 SHALL use the zig-zag-to-raster map ZZ = {0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15}.
REQ-018 SHALL, on BlockDone: mark the write bank FULL, toggle the write-bank pointer, and zero WrCnt.
REQ-019 SHALL process a WrReq in the same cycle as BlockDone before closing the block, so the final coefficient is included.
REQ-020 SHALL treat BlockDone with fewer than 16 writes as a valid short block; unwritten positions (mask bit clear) read as 0.
REQ-021 SHALL clear a bank's mask when the bank is freed, so stale data never appears.
REQ-022 SHALL drop any WrReq with WrCnt==16 and set Overflow.
REQ-023 SHALL drop any WrReq or BlockDone that arrives while Full is high, and set Overflow; no bank state changes.
REQ-024 SHALL drive Full high combinationally whenever both banks are FULL.
REQ-025 SHALL implement the read FSM with two states:
- IDLE -> SEND when the read bank is FULL.
- SEND -> SEND on each transfer while CoefIdx<15, with CoefIdx incrementing.
- SEND -> IDLE on the transfer with CoefIdx==15: the read bank is freed and the read pointer toggles.
REQ-026 SHALL register all outputs; CoefValid rises no earlier than 1 cycle after the BlockDone edge that fills a bank (minimum latency of 1 cycle).
REQ-027 SHALL hold CoefOut, CoefIdx and CoefLast stable while CoefValid is high and CoefReady is low.
REQ-028 SHALL, when a bank is freed and the other bank is already FULL, go directly into SEND for the next block, giving back-to-back blocks with no idle cycle.
REQ-029 SHALL allow a free (read side) and a BlockDone (write side) on different banks in the same cycle; both take effect and Full deasserts or holds accordingly.
REQ-030 SHALL make a bank freed in cycle N writable from cycle N+1.

Reset
REQ-031 SHALL, while nReset is low, asynchronously force:
- both banks FREE, masks 0;
- pointers 0, WrCnt 0, FSM IDLE;
- CoefValid 0, CoefOut 0, CoefIdx 0, CoefLast 0;
- Full 0, Overflow 0.
REQ-032 SHALL abandon any partial block, both on the write side and mid-SEND, when reset occurs; no further output until a new BlockDone.
REQ-033 SHALL release reset synchronously to Clk.

Verification
REQ-034 Full block: write 1..16 in scan order, then BlockDone, CoefReady=1 -> 16 transfers, with CoefOut at raster idx 0..15 = 1,2,6,7,3,5,8,13,4,9,12,14,10,11,15,16 and CoefLast on the 16th.
REQ-035 Short block: writes 5,-3 then BlockDone in the same cycle as the second write -> idx0=5, idx1=-3, idx2..15=0.
REQ-036 Backpressure: three blocks with CoefReady=0 -> Full high after the second BlockDone; the third write is dropped and Overflow=1; release CoefReady -> two blocks out back-to-back, the second starting the cycle after the first's CoefLast.
REQ-037 Overflow by count: 17 writes before BlockDone -> the first 16 are stored, Overflow=1, the output block is correct.
REQ-038 Empty block: BlockDone with no writes -> 16 zeros.
REQ-039 Reset mid-SEND at CoefIdx=7 -> all outputs 0 immediately; the next full block is output correctly from idx 0.
